// File: rtl/instr_fetch_reader.sv
// Instruction-fetch bus initiator: reads a block of consecutive words with
// pipelined requests and streams them out in order through a response FIFO.
module instr_fetch_reader #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int LEN_W           = 16,
  parameter int TIMEOUT         = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      start_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             instr_req_o,
  output logic [31:0]      instr_addr_o,
  input  logic             instr_gnt_i,
  input  logic             instr_rvalid_i,
  input  logic [31:0]      instr_rdata_i,
  input  logic             instr_err_i,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [31:0]      data_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // RUN   | issuing requests
  // DRAIN | no new issue; wait for outstanding responses and an empty FIFO
  // DONE  | one-cycle done_o pulse

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_remaining;
  logic [OW-1:0]    r_outstanding;
  logic [TW-1:0]    r_to_cnt;
  logic             r_err;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_req, w_gnt_acc, w_rv_acc, w_bus_err, w_timeout, w_push, w_pop, w_start;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit check counts in-flight words against free FIFO slots, so a push never meets a full FIFO.
  always_comb begin
    w_req     = (r_state == S_RUN) && (r_remaining != '0) && (r_outstanding < OUT_MAX)
                && ((32'(r_outstanding) + 32'(r_count)) < 32'(FIFO_DEPTH));
    w_gnt_acc = w_req && instr_gnt_i;
    w_rv_acc  = instr_rvalid_i && (r_outstanding != '0);
    w_bus_err = w_rv_acc && instr_err_i;
    w_timeout = w_req && !instr_gnt_i && (r_to_cnt == TW'(1));
    w_push    = w_rv_acc && !instr_err_i && !r_err;
    w_pop     = (r_count != '0) && data_ready_i;
    w_start   = (r_state == S_IDLE) && start_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = (len_i != '0) ? S_RUN : S_DONE;
      S_RUN:   if (w_bus_err || w_timeout || (r_remaining == '0)) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_outstanding == '0) && (r_count == '0)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_to_cnt      <= TO_LOAD;
      r_err         <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start) begin
        r_addr      <= {start_addr_i[31:2], 2'b00};
        r_remaining <= len_i;
        r_err       <= 1'b0;
      end else if (w_gnt_acc) begin
        r_addr      <= r_addr + 32'd4;
        r_remaining <= r_remaining - LEN_W'(1);
      end

      if (w_bus_err || w_timeout) r_err <= 1'b1;

      unique case ({w_gnt_acc, w_rv_acc})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      // Terminal count of 1 marks the TIMEOUT-th cycle of an ungranted request.
      if (w_req && !instr_gnt_i) r_to_cnt <= (r_to_cnt == TW'(1)) ? TO_LOAD : r_to_cnt - TW'(1);
      else                       r_to_cnt <= TO_LOAD;

      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      assert (!(w_push && !w_pop && (r_count == CNT_FULL)));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= instr_rdata_i;
  end

  always_comb begin
    busy_o       = (r_state != S_IDLE);
    done_o       = (r_state == S_DONE);
    err_o        = r_err;
    instr_req_o  = w_req;
    instr_addr_o = r_addr;
    data_valid_o = (r_count != '0);
    data_o       = data_valid_o ? r_mem[r_rd_ptr] : 32'd0;
  end

endmodule

// File: tb/tb_instr_fetch_reader.sv
// Bench for instr_fetch_reader: randomized bus responder plus an address-based
// reference of the words each transfer must deliver.
module tb_instr_fetch_reader;

  localparam int MAXO = 2;
  localparam int DEPTH = 4;
  localparam int TO = 64;

  logic        clk, rst, start_i;
  logic [31:0] start_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o, instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic        data_valid_o, data_ready_i;
  logic [31:0] data_o;

  instr_fetch_reader #(.MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(DEPTH), .LEN_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // responder configuration and bookkeeping
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];
  rsp_t e;
  int gmax = 0, lmin = 1, lmax = 1, err_at = -1;
  bit limit_en = 1, chk_proto = 0;
  int gwait = -1, last_due = 0, rsp_idx = 0, grants = 0, outst_tb = 0, max_out = 0;
  int proto_viol = 0, req_after_err = 0, err_sent_cyc = 0;
  bit err_sent = 0, prev_pend = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] gnt_addrs[$];

  // observation
  logic [31:0] got[$];
  int got_cyc[$];
  int done_cnt = 0, done_before = 0, req_cyc = 0, start_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h80:  return 32'h00000513;
      32'h84:  return 32'h000015b7;
      32'h88:  return 32'h00a58223;
      32'h8C:  return 32'h00150513;
      32'h90:  return 32'hff9ff06f;
      default: return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    int lat, due;
    logic g;
    #1;
    instr_rvalid_i = 1'b0;
    instr_err_i    = 1'b0;
    instr_rdata_i  = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      e = rq.pop_front();
      instr_rvalid_i = 1'b1;
      if (rsp_idx == err_at) begin
        instr_err_i  = 1'b1;
        err_sent     = 1'b1;
        err_sent_cyc = cyc;
      end else begin
        instr_rdata_i = mem_word(e.addr);
      end
      rsp_idx++;
      outst_tb--;
    end
    if (chk_proto && prev_pend && (!instr_req_o || instr_addr_o !== prev_addr)) proto_viol++;
    if (err_sent && err_sent_cyc < cyc && instr_req_o) req_after_err++;
    g = 1'b0;
    if (instr_req_o && !rst) begin
      if (gwait < 0) gwait = int'($urandom_range(gmax, 0));
      if (gwait == 0 && (!limit_en || instr_addr_o < 32'h100)) begin
        g   = 1'b1;
        lat = int'($urandom_range(lmax, lmin));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq.push_back('{addr: instr_addr_o, due: due});
        gnt_addrs.push_back(instr_addr_o);
        grants++;
        outst_tb++;
        gwait = -1;
      end else if (gwait > 0) begin
        gwait--;
      end
      prev_pend = !g;
      prev_addr = instr_addr_o;
    end else begin
      gwait     = -1;
      prev_pend = 1'b0;
    end
    if (outst_tb > max_out) max_out = outst_tb;
    instr_gnt_i = g;
  end

  always @(negedge clk) begin
    if (!rst && data_valid_o && data_ready_i) begin
      got.push_back(data_o);
      got_cyc.push_back(cyc);
    end
    if (done_o) done_cnt++;
    if (instr_req_o) req_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_xfer(input logic [31:0] a, input int l);
    got.delete(); got_cyc.delete(); gnt_addrs.delete();
    grants = 0; req_cyc = 0; rsp_idx = 0; err_sent = 0; req_after_err = 0;
    proto_viol = 0; max_out = 0; outst_tb = 0; done_before = done_cnt;
    start_i = 1'b1; start_addr_i = a; len_i = 16'(l);
    tick();
    start_cyc = cyc;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == done_before && n < budget) begin
      if (rnd) data_ready_i = 1'($urandom_range(1, 0));
      tick();
      n++;
    end
    data_ready_i = 1'b1;
    chk({tag, " done pulses"}, 32'(done_cnt - done_before), 32'd1);
  endtask

  task automatic settle();
    int n = 0;
    while ((rq.size() != 0 || busy_o) && n < 60) begin
      tick();
      n++;
    end
    tick(); tick();
  endtask

  task automatic check_words(input string tag, input logic [31:0] a, input int n);
    chk({tag, " word count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s word%0d", tag, i), got[i], mem_word(a + 32'(4 * i)));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy_o"}, 32'(busy_o), 32'd0);
    chk({tag, " done_o"}, 32'(done_o), 32'd0);
    chk({tag, " err_o"}, 32'(err_o), 32'd0);
    chk({tag, " req"}, 32'(instr_req_o), 32'd0);
    chk({tag, " data_valid_o"}, 32'(data_valid_o), 32'd0);
    chk({tag, " data_o"}, data_o, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_a;
    rst = 1'b1; start_i = 1'b0; start_addr_i = '0; len_i = '0; data_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // basic 5-word copy from the boot ROM window
    data_ready_i = 1'b1;
    start_xfer(32'h80, 5);
    wait_done("t1", 100, 1'b0);
    check_words("t1", 32'h80, 5);
    if (got.size() == 5) begin
      chk("t1 first word latency", 32'(got_cyc[0] - start_cyc), 32'd2);
      chk("t1 throughput span", 32'(got_cyc[4] - got_cyc[0]), 32'd4);
    end
    chk("t1 err_o", 32'(err_o), 32'd0);
    settle();

    // consumer stalled: issue must stop at FIFO credit
    data_ready_i = 1'b0;
    start_xfer(32'h80, 5);
    repeat (20) tick();
    chk("t2 grants while stalled", 32'(grants), 32'(DEPTH));
    chk("t2 req low while stalled", 32'(instr_req_o), 32'd0);
    chk("t2 data_valid while stalled", 32'(data_valid_o), 32'd1);
    data_ready_i = 1'b1;
    wait_done("t2", 100, 1'b0);
    check_words("t2", 32'h80, 5);
    settle();

    // random grant/response latency and random backpressure
    gmax = 3; lmin = 1; lmax = 3; chk_proto = 1'b1;
    start_xfer(32'h0, 40);
    wait_done("t3", 2000, 1'b1);
    chk_proto = 1'b0;
    chk("t3 req/addr stable until gnt", 32'(proto_viol), 32'd0);
    chk("t3 outstanding within limit", 32'(max_out <= MAXO), 32'd1);
    chk("t3 grants", 32'(grants), 32'd40);
    check_words("t3", 32'h0, 40);
    chk("t3 err_o", 32'(err_o), 32'd0);
    settle();

    // bus error on the third response
    gmax = 0; lmin = 1; lmax = 1; err_at = 2;
    start_xfer(32'h80, 8);
    wait_done("t4", 200, 1'b0);
    check_words("t4", 32'h80, 2);
    chk("t4 err_o", 32'(err_o), 32'd1);
    chk("t4 req after err", 32'(req_after_err), 32'd0);
    err_at = -1;
    settle();

    // responder never grants above 0x100: timeout
    start_xfer(32'h1000, 3);
    wait_done("t5", 300, 1'b0);
    chk("t5 req cycles", 32'(req_cyc), 32'(TO));
    chk("t5 err_o", 32'(err_o), 32'd1);
    chk("t5 word count", 32'(got.size()), 32'd0);
    settle();

    // zero-length transfer, also clears the sticky error
    start_xfer(32'h40, 0);
    chk("t6a done_o after start", 32'(done_o), 32'd1);
    chk("t6a err_o cleared", 32'(err_o), 32'd0);
    repeat (3) tick();
    chk("t6a done pulses", 32'(done_cnt - done_before), 32'd1);
    chk("t6a req cycles", 32'(req_cyc), 32'd0);
    chk("t6a word count", 32'(got.size()), 32'd0);
    settle();

    // address wrap at the top of the address space
    limit_en = 1'b0;
    start_xfer(32'hFFFFFFF8, 3);
    wait_done("t6b", 100, 1'b0);
    chk("t6b grants", 32'(grants), 32'd3);
    exp_a = 32'hFFFFFFF8;
    for (int i = 0; i < 3 && i < gnt_addrs.size(); i++) begin
      chk($sformatf("t6b addr%0d", i), gnt_addrs[i], exp_a);
      exp_a = exp_a + 32'd4;
    end
    check_words("t6b", 32'hFFFFFFF8, 3);
    limit_en = 1'b1;
    settle();

    // reset mid-transfer; responses still in flight must be ignored
    lmin = 3; lmax = 3; data_ready_i = 1'b0;
    start_xfer(32'h0, 10);
    tick(); tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("t6c after rst");
    rst = 1'b0;
    repeat (6) tick();
    chk("t6c data_valid after stale rvalid", 32'(data_valid_o), 32'd0);
    chk("t6c busy_o after reset", 32'(busy_o), 32'd0);
    chk("t6c no done after reset", 32'(done_cnt - done_before), 32'd0);
    settle();

    // normal operation resumes after the aborted run
    lmin = 1; lmax = 1; data_ready_i = 1'b1;
    start_xfer(32'h80, 5);
    wait_done("t6d", 100, 1'b0);
    check_words("t6d", 32'h80, 5);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
